branch_unit_ras: RTL and testbench

Parametrised next-generation branch/PC unit for the KGP-RISC datapath. It owns the program-counter register and resolves sequential flow, register jumps and flag-conditional branches. Carry is held in a latched flag register that updates only on enabled cycles. The unit adds call/return through a circular return-address stack (RAS). It sits between decode/ALU and instruction memory and drives the fetch address every cycle.

---
 rtl/branch_unit_ras.sv | 128 ++++++++++++
 tb/tb_branch_unit_ras.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/branch_unit_ras.sv
`default_nettype none
// ============================================================================
// Module   : branch_unit_ras
// Purpose  : PC register, jump/branch resolution, latched carry flag and a
//            circular return-address stack for call/return.
// Revision : 1.0 - initial release
// ============================================================================
module branch_unit_ras #(
    parameter int                ADDR_W    = 32,
    parameter int                RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic [1:0]        branch_ctrl,
    input  logic [4:0]        funct,
    input  logic [2:0]        alu_flags,
    input  logic              flags_valid,
    input  logic [ADDR_W-1:0] branch_address,
    input  logic [ADDR_W-1:0] read_1,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    output logic [ADDR_W-1:0] pc_next,
    output logic              taken,
    output logic              ras_full,
    output logic              ras_empty,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    localparam int                C_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [C_PTR_W:0]  C_FULL  = (C_PTR_W+1)'(RAS_DEPTH);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               cflag_q;
    logic [ADDR_W-1:0]  ras_q [RAS_DEPTH];
    logic [C_PTR_W-1:0] top_q;
    logic [C_PTR_W:0]   cnt_q;
    logic               ovf_q, unf_q;

    logic               w_taken, w_push, w_pop, w_unf;
    logic [C_PTR_W-1:0] w_top_inc;

    assign pc            = pc_q;
    assign pc_plus       = pc_q + ADDR_W'(1);
    assign pc_next       = pc_d;
    assign taken         = w_taken;
    assign ras_full      = (cnt_q == C_FULL);
    assign ras_empty     = (cnt_q == '0);
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
    assign w_top_inc     = top_q + C_PTR_W'(1);

    always_comb begin
        pc_d    = pc_plus;
        w_taken = 1'b0;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        w_unf   = 1'b0;
        case (branch_ctrl)
            2'b01: begin
                case (funct)
                    5'd0: begin pc_d = read_1; w_taken = 1'b1; end
                    5'd1: if (alu_flags[1])  begin pc_d = branch_address; w_taken = 1'b1; end
                    5'd2: if (alu_flags[0])  begin pc_d = branch_address; w_taken = 1'b1; end
                    5'd3: if (!alu_flags[0]) begin pc_d = branch_address; w_taken = 1'b1; end
                    default: ;
                endcase
            end
            2'b10: begin
                case (funct)
                    5'd0: begin pc_d = branch_address; w_taken = 1'b1; end
                    5'd1: if (cflag_q)  begin pc_d = branch_address; w_taken = 1'b1; end
                    5'd2: if (!cflag_q) begin pc_d = branch_address; w_taken = 1'b1; end
                    default: ;
                endcase
            end
            2'b11: begin
                if (funct == 5'd2) begin
                    // Return on an empty stack falls through and flags the underflow.
                    if (cnt_q != '0) begin
                        pc_d    = ras_q[top_q];
                        w_taken = 1'b1;
                        w_pop   = 1'b1;
                    end else begin
                        w_unf   = 1'b1;
                    end
                end else begin
                    pc_d    = branch_address;
                    w_taken = 1'b1;
                    w_push  = (funct == 5'd1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            cflag_q <= 1'b0;
            top_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (!stall) begin
            pc_q <= pc_d;
            if (flags_valid) cflag_q <= alu_flags[2];
            if (w_push) begin
                top_q <= w_top_inc;
                if (cnt_q == C_FULL) ovf_q <= 1'b1;
                else                 cnt_q <= cnt_q + 1'b1;
            end else if (w_pop) begin
                top_q <= top_q - C_PTR_W'(1);
                cnt_q <= cnt_q - 1'b1;
            end
            if (w_unf) unf_q <= 1'b1;
        end
    end

    // Entry storage needs no reset: count gates every read.
    always_ff @(posedge clock) begin
        if (!reset && !stall && w_push) ras_q[w_top_inc] <= pc_plus;
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_unit_ras.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_unit_ras
// Purpose  : Scoreboard bench for branch_unit_ras against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_unit_ras;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, stall, flags_valid;
    logic [1:0]  branch_ctrl;
    logic [4:0]  funct;
    logic [2:0]  alu_flags;
    logic [31:0] branch_address, read_1;
    logic [31:0] pc, pc_plus, pc_next;
    logic        taken, ras_full, ras_empty, ras_overflow, ras_underflow;

    always #5 clk = ~clk;

    branch_unit_ras #(.ADDR_W(32), .RAS_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clock(clk), .reset(reset), .stall(stall), .branch_ctrl(branch_ctrl),
        .funct(funct), .alu_flags(alu_flags), .flags_valid(flags_valid),
        .branch_address(branch_address), .read_1(read_1),
        .pc(pc), .pc_plus(pc_plus), .pc_next(pc_next), .taken(taken),
        .ras_full(ras_full), .ras_empty(ras_empty),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    typedef struct {
        logic [31:0] pc, pc_plus, pc_next;
        logic        taken, full, empty, ovf, unf;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;

    // Architectural model: return addresses live in a plain queue, newest at the back.
    logic [31:0] m_pc;
    logic        m_cf, m_ovf, m_unf, m_valid = 1'b0;
    logic [31:0] m_ras[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc",        pc,                    e.pc);
                chk("pc_plus",   pc_plus,               e.pc_plus);
                chk("pc_next",   pc_next,               e.pc_next);
                chk("taken",     {31'd0, taken},         {31'd0, e.taken});
                chk("ras_full",  {31'd0, ras_full},      {31'd0, e.full});
                chk("ras_empty", {31'd0, ras_empty},     {31'd0, e.empty});
                chk("overflow",  {31'd0, ras_overflow},  {31'd0, e.ovf});
                chk("underflow", {31'd0, ras_underflow}, {31'd0, e.unf});
            end
        end
    end

    task automatic step(input logic rst, input logic st, input logic [1:0] bc,
                        input logic [4:0] fn, input logic [2:0] fl, input logic fv,
                        input logic [31:0] ba, input logic [31:0] r1);
        exp_t        e;
        logic [31:0] nxt, pp;
        logic        tk, psh, pp_pop, und;
        @(posedge clk);
        #1;
        reset = rst; stall = st; branch_ctrl = bc; funct = fn;
        alu_flags = fl; flags_valid = fv; branch_address = ba; read_1 = r1;
        pp = m_pc + 32'd1;
        nxt = pp; tk = 1'b0; psh = 1'b0; pp_pop = 1'b0; und = 1'b0;
        if (bc == 2'b01) begin
            if (fn == 5'd0)                    begin nxt = r1; tk = 1'b1; end
            else if (fn == 5'd1 && fl[1])      begin nxt = ba; tk = 1'b1; end
            else if (fn == 5'd2 && fl[0])      begin nxt = ba; tk = 1'b1; end
            else if (fn == 5'd3 && !fl[0])     begin nxt = ba; tk = 1'b1; end
        end else if (bc == 2'b10) begin
            if (fn == 5'd0 || (fn == 5'd1 && m_cf) || (fn == 5'd2 && !m_cf)) begin
                nxt = ba; tk = 1'b1;
            end
        end else if (bc == 2'b11) begin
            if (fn != 5'd2) begin
                nxt = ba; tk = 1'b1; psh = (fn == 5'd1);
            end else if (m_ras.size() > 0) begin
                nxt = m_ras[$]; tk = 1'b1; pp_pop = 1'b1;
            end else begin
                und = 1'b1;
            end
        end
        if (!rst && m_valid) begin
            e.pc = m_pc; e.pc_plus = pp; e.pc_next = nxt; e.taken = tk;
            e.full = (m_ras.size() == DEPTH); e.empty = (m_ras.size() == 0);
            e.ovf = m_ovf; e.unf = m_unf;
            sb.push_back(e);
        end
        if (rst) begin
            m_pc = 32'h0; m_cf = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            m_ras.delete(); m_valid = 1'b1;
        end else if (!st) begin
            m_pc = nxt;
            if (fv) m_cf = fl[2];
            if (psh) begin
                m_ras.push_back(pp);
                if (m_ras.size() > DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
            end
            if (pp_pop) void'(m_ras.pop_back());
            if (und) m_unf = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_ctrl = '0; funct = '0; alu_flags = '0;
        flags_valid = 1'b0; branch_address = '0; read_1 = '0;
        // Reset under stall, sequential flow, then one stalled cycle.
        step(1, 1, 2'b00, 0, 3'b000, 0, 0, 0);
        repeat (3) step(0, 0, 2'b00, 0, 3'b000, 0, 0, 0);
        step(0, 1, 2'b00, 0, 3'b000, 0, 0, 0);
        // Current-flag branches and jr from pc=10.
        step(0, 0, 2'b10, 0, 3'b000, 0, 32'd10, 0);
        step(0, 0, 2'b01, 1, 3'b010, 0, 32'd40, 0);
        step(0, 0, 2'b10, 0, 3'b000, 0, 32'd10, 0);
        step(0, 0, 2'b01, 1, 3'b000, 0, 32'd40, 0);
        step(0, 0, 2'b01, 0, 3'b000, 0, 0, 32'd77);
        step(0, 0, 2'b01, 2, 3'b001, 0, 32'd90, 0);
        step(0, 0, 2'b01, 3, 3'b001, 0, 32'd95, 0);
        // Carry latch: bcy in the write cycle sees the old flag.
        step(0, 0, 2'b10, 1, 3'b100, 1, 32'd50, 0);
        step(0, 0, 2'b10, 1, 3'b000, 0, 32'd50, 0);
        step(0, 0, 2'b00, 0, 3'b000, 0, 0, 0);
        step(0, 0, 2'b10, 2, 3'b000, 0, 32'd60, 0);
        step(0, 0, 2'b10, 1, 3'b000, 0, 32'd70, 0);
        // Nested call/return.
        step(0, 0, 2'b11, 0, 3'b000, 0, 32'd5, 0);
        step(0, 0, 2'b11, 1, 3'b000, 0, 32'd100, 0);
        step(0, 0, 2'b11, 1, 3'b000, 0, 32'd200, 0);
        step(0, 0, 2'b11, 2, 3'b000, 0, 0, 0);
        step(0, 0, 2'b11, 2, 3'b000, 0, 0, 0);
        // Overflow then underflow.
        step(0, 0, 2'b11, 0, 3'b000, 0, 32'd1, 0);
        for (int i = 1; i <= 5; i++) step(0, 0, 2'b11, 1, 3'b000, 0, 32'(i + 1), 0);
        for (int i = 0; i < 5; i++)  step(0, 0, 2'b11, 2, 3'b000, 0, 0, 0);
        // Stalled call and return must not touch the stack.
        step(0, 1, 2'b11, 1, 3'b000, 0, 32'd300, 0);
        step(0, 0, 2'b11, 1, 3'b000, 0, 32'd300, 0);
        step(0, 1, 2'b11, 2, 3'b000, 0, 0, 0);
        step(0, 0, 2'b00, 0, 3'b000, 0, 0, 0);
        // Reset in a call cycle discards the push.
        step(1, 0, 2'b11, 1, 3'b000, 0, 32'd500, 0);
        step(0, 0, 2'b11, 2, 3'b000, 0, 0, 0);
        step(0, 0, 2'b00, 0, 3'b000, 0, 0, 0);
        // Wraparound of pc at all-ones.
        step(0, 0, 2'b10, 0, 3'b000, 0, 32'hFFFF_FFFF, 0);
        step(0, 0, 2'b00, 0, 3'b000, 0, 0, 0);
        step(0, 0, 2'b00, 0, 3'b000, 0, 0, 0);
        // Randomized traffic biased toward calls/returns.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] bc;
            logic [4:0] fn;
            bc = 2'($urandom_range(0, 3));
            fn = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, bc, fn,
                 3'($urandom), 1'($urandom), $urandom, $urandom);
        end
        step(0, 0, 2'b00, 0, 3'b000, 0, 0, 0);
        repeat (4) @(posedge clk);
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
